// File: rtl/comm_pkg.sv
// Shared types and widths for the host-side command link (remote_comm).
package comm_pkg;

  localparam int CMD_W  = 16;
  localparam int BYTE_W = 8;

  // Transmit sequencer: idle, sending the high byte, sending the low byte.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TX_HIGH = 2'd1,
    TX_LOW  = 2'd2
  } state_t;

endpackage : comm_pkg

// File: rtl/remote_comm_uart.sv
// 8N1 UART transceiver used for both directions of the command link.
// trmt is a 1-cycle start pulse; tx_done rises at the end of the stop bit and
// falls on the next trmt. rdy holds until clr_rdy; a clear that coincides with
// a new byte wins for that cycle only and rdy rises one cycle later.
module UART
  import comm_pkg::*;
#(
  parameter int BAUD_CYCLES = 2604
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  output logic              TX,
  input  logic              trmt,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_done,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rdy,
  input  logic              clr_rdy
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_CYCLES - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_CYCLES / 2 - 1);

  logic [9:0]        tx_shift_r;
  logic              tx_busy_r;
  logic [15:0]       tx_baud_r;
  logic [3:0]        tx_bit_r;
  logic              tx_done_r;
  logic              rx_ff1_r;
  logic              rx_ff2_r;
  logic              rx_busy_r;
  logic [15:0]       rx_baud_r;
  logic [3:0]        rx_bit_r;
  logic [BYTE_W-1:0] rx_shift_r;
  logic [BYTE_W-1:0] rx_data_r;
  logic              rdy_r;
  logic              rdy_pend_r;
  logic              rx_done_s;

  // Transmitter: load a start/data/stop frame and shift it out LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_r <= 10'h3FF;
      tx_busy_r  <= 1'b0;
      tx_baud_r  <= 16'd0;
      tx_bit_r   <= 4'd0;
      tx_done_r  <= 1'b0;
    end else if (trmt) begin
      tx_shift_r <= {1'b1, tx_data, 1'b0};
      tx_busy_r  <= 1'b1;
      tx_baud_r  <= 16'd0;
      tx_bit_r   <= 4'd0;
      tx_done_r  <= 1'b0;
    end else if (tx_busy_r) begin
      if (tx_baud_r == BAUD_LAST) begin
        tx_baud_r  <= 16'd0;
        tx_shift_r <= {1'b1, tx_shift_r[9:1]};
        if (tx_bit_r == 4'd9) begin
          tx_busy_r <= 1'b0;
          tx_done_r <= 1'b1;
          tx_bit_r  <= 4'd0;
        end else begin
          tx_bit_r <= tx_bit_r + 4'd1;
        end
      end else begin
        tx_baud_r <= tx_baud_r + 16'd1;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous serial input (idles high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1_r <= 1'b1;
      rx_ff2_r <= 1'b1;
    end else begin
      rx_ff1_r <= RX;
      rx_ff2_r <= rx_ff1_r;
    end
  end

  // Stop-bit sample of a frame in progress marks a completed byte.
  always_comb begin
    rx_done_s = rx_busy_r && (rx_baud_r == 16'd0) && (rx_bit_r == 4'd9);
  end

  // Receiver: detect start, sample each bit mid-cell, assemble the byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy_r  <= 1'b0;
      rx_baud_r  <= 16'd0;
      rx_bit_r   <= 4'd0;
      rx_shift_r <= 8'h00;
      rx_data_r  <= 8'h00;
    end else if (!rx_busy_r) begin
      if (rx_ff2_r == 1'b0) begin
        rx_busy_r <= 1'b1;
        rx_baud_r <= HALF_LAST;
        rx_bit_r  <= 4'd0;
      end
    end else if (rx_baud_r == 16'd0) begin
      rx_baud_r <= BAUD_LAST;
      if (rx_bit_r == 4'd9) begin
        rx_busy_r <= 1'b0;
        rx_bit_r  <= 4'd0;
        rx_data_r <= rx_shift_r;
      end else if ((rx_bit_r == 4'd0) && (rx_ff2_r == 1'b1)) begin
        // Start bit vanished by mid-cell: treat as a glitch.
        rx_busy_r <= 1'b0;
      end else begin
        if (rx_bit_r != 4'd0) begin
          rx_shift_r <= {rx_ff2_r, rx_shift_r[7:1]};
        end
        rx_bit_r <= rx_bit_r + 4'd1;
      end
    end else begin
      rx_baud_r <= rx_baud_r - 16'd1;
    end
  end

  // Ready flag: a clear that collides with a new byte defers the set by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_r      <= 1'b0;
      rdy_pend_r <= 1'b0;
    end else if (rx_done_s && clr_rdy) begin
      rdy_r      <= 1'b0;
      rdy_pend_r <= 1'b1;
    end else if (rx_done_s) begin
      rdy_r      <= 1'b1;
      rdy_pend_r <= 1'b0;
    end else if (clr_rdy) begin
      rdy_r      <= 1'b0;
      rdy_pend_r <= 1'b0;
    end else if (rdy_pend_r) begin
      rdy_r      <= 1'b1;
      rdy_pend_r <= 1'b0;
    end
  end

  assign TX      = tx_shift_r[0];
  assign tx_done = tx_done_r;
  assign rx_data = rx_data_r;
  assign rdy     = rdy_r;

endmodule : UART

// File: rtl/remote_comm.sv
// Host-side command link: sends a 16-bit command as two UART bytes (high byte
// first) and receives a 1-byte response.
// Optional build macro RESP_TIMEOUT_EN adds the resp_timeout output and a
// response watchdog of TIMEOUT_CYCLES clocks after cmd_sent.
module remote_comm
  import comm_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
  parameter int          BAUD_CYCLES    = 2604
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  cmd,
  input  logic              snd_cmd,
  input  logic              clr_resp_rdy,
  input  logic              RX,
  output logic              TX,
  output logic              cmd_sent,
  output logic              resp_rdy,
  output logic [BYTE_W-1:0] resp
`ifdef RESP_TIMEOUT_EN
  ,
  output logic              resp_timeout
`endif
);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [BYTE_W-1:0] low_byte_r;
  logic              cmd_sent_r;
  logic              accept_s;
  logic              trmt_s;
  logic [BYTE_W-1:0] tx_data_s;
  logic              tx_done_s;
  logic              clr_rdy_s;

  // Sequencer: accept a command in IDLE, chain the low byte after the high byte.
  always_comb begin
    state_nxt_s = state_r;
    trmt_s      = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (snd_cmd) begin
          accept_s    = 1'b1;
          trmt_s      = 1'b1;
          state_nxt_s = TX_HIGH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      TX_HIGH: begin
        if (tx_done_s) begin
          trmt_s      = 1'b1;
          state_nxt_s = TX_LOW;
        end else begin
          state_nxt_s = TX_HIGH;
        end
      end
      TX_LOW: begin
        if (tx_done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = TX_LOW;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Byte to send: live high byte at accept, otherwise the captured low byte.
  always_comb begin
    if (state_r == IDLE) begin
      tx_data_s = cmd[15:8];
    end else begin
      tx_data_s = low_byte_r;
    end
    clr_rdy_s = clr_resp_rdy | accept_s;
  end

  // State register and low-byte capture so cmd may change after the accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      low_byte_r <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        low_byte_r <= cmd[7:0];
      end
    end
  end

  // cmd_sent: sticky once the low byte finishes, cleared by the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_sent_r <= 1'b0;
    end else if (accept_s) begin
      cmd_sent_r <= 1'b0;
    end else if ((state_r == TX_LOW) && tx_done_s) begin
      cmd_sent_r <= 1'b1;
    end
  end

`ifdef RESP_TIMEOUT_EN
  logic [23:0] to_cnt_r;

  // Response watchdog: counts while waiting for a reply, then latches timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r     <= 24'd0;
      resp_timeout <= 1'b0;
    end else if (accept_s) begin
      to_cnt_r     <= 24'd0;
      resp_timeout <= 1'b0;
    end else if (cmd_sent_r && !resp_rdy && !resp_timeout) begin
      if (to_cnt_r == (TIMEOUT_CYCLES - 24'd1)) begin
        resp_timeout <= 1'b1;
      end else begin
        to_cnt_r <= to_cnt_r + 24'd1;
      end
    end
  end
`endif

  UART #(
    .BAUD_CYCLES(BAUD_CYCLES)
  ) u_uart (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .TX      (TX),
    .trmt    (trmt_s),
    .tx_data (tx_data_s),
    .tx_done (tx_done_s),
    .rx_data (resp),
    .rdy     (resp_rdy),
    .clr_rdy (clr_rdy_s)
  );

  assign cmd_sent = cmd_sent_r;

endmodule : remote_comm

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm: decodes the serial TX line, drives RX frames.
module tb_remote_comm;

  localparam int BAUD = 8;
  localparam int HALF = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        clr_resp_rdy;
  logic        RX;
  logic        TX;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;
`ifdef RESP_TIMEOUT_EN
  logic        resp_timeout;
`endif

  int checks;
  int errors;
  logic [7:0] rxq[$];

  remote_comm #(
    .TIMEOUT_CYCLES(24'd1000),
    .BAUD_CYCLES   (BAUD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .snd_cmd     (snd_cmd),
    .clr_resp_rdy(clr_resp_rdy),
    .RX          (RX),
    .TX          (TX),
    .cmd_sent    (cmd_sent),
    .resp_rdy    (resp_rdy),
    .resp        (resp)
`ifdef RESP_TIMEOUT_EN
    ,
    .resp_timeout(resp_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial decoder for TX: samples mid-bit on falling clock edges.
  initial begin
    logic [7:0] b;
    logic       ok;
    forever begin
      @(negedge clk);
      if (rst_n && (TX == 1'b0)) begin
        ok = 1'b1;
        b  = 8'h00;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          if (!rst_n) ok = 1'b0;
          b[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        if (!rst_n || (TX !== 1'b1)) ok = 1'b0;
        if (ok) rxq.push_back(b);
      end
    end
  end

  function automatic logic [15:0] two_bytes();
    if (rxq.size() == 2) return {rxq[0], rxq[1]};
    return 16'hxxxx;
  endfunction

  task automatic send_cmd(input logic [15:0] c);
    @(negedge clk);
    cmd     = c;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
  endtask

  // Returns the number of rising edges after the accept edge until cmd_sent.
  task automatic wait_sent(output int n);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      n = n + 1;
      if (cmd_sent) break;
    end
    if (!cmd_sent) n = -1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = 1'b1;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd = 16'h0000; snd_cmd = 1'b0; clr_resp_rdy = 1'b0; RX = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", TX); end
    checks++; if (cmd_sent !== 1'b0) begin errors++; $display("FAIL reset_cmd_sent got %b exp 0", cmd_sent); end
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_resp_rdy got %b exp 0", resp_rdy); end
    checks++; if (resp !== 8'h00) begin errors++; $display("FAIL reset_resp got %h exp 00", resp); end
`ifdef RESP_TIMEOUT_EN
    checks++; if (resp_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", resp_timeout); end
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic_cmd();
    int n;
    rxq.delete();
    send_cmd(16'hA55A);
    wait_sent(n);
    checks++; if (n != 162) begin errors++; $display("FAIL sent_latency got %0d exp 162", n); end
    checks++; if (two_bytes() !== 16'hA55A) begin errors++; $display("FAIL basic_bytes got %h exp a55a", two_bytes()); end
  endtask

  task automatic test_response();
    send_rx(8'hA5);
    repeat (2) @(negedge clk);
    checks++; if (resp_rdy !== 1'b1) begin errors++; $display("FAIL resp_rdy_set got %b exp 1", resp_rdy); end
    checks++; if (resp !== 8'hA5) begin errors++; $display("FAIL resp_value got %h exp a5", resp); end
    clr_resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL resp_clr got %b exp 0", resp_rdy); end
    @(negedge clk);
    clr_resp_rdy = 1'b0;
  endtask

  task automatic test_ignored_snd();
    int n;
    rxq.delete();
    send_cmd(16'h00FF);
    repeat (20) @(negedge clk);
    send_cmd(16'h1234);
    wait_sent(n);
    checks++; if (n < 0) begin errors++; $display("FAIL ignored_sent got timeout exp rise"); end
    repeat (200) @(negedge clk);
    checks++; if (rxq.size() != 2) begin errors++; $display("FAIL ignored_count got %0d exp 2", rxq.size()); end
    checks++; if (two_bytes() !== 16'h00FF) begin errors++; $display("FAIL ignored_bytes got %h exp 00ff", two_bytes()); end
    checks++; if (cmd_sent !== 1'b1) begin errors++; $display("FAIL ignored_sticky got %b exp 1", cmd_sent); end
  endtask

  task automatic test_held_low_byte();
    int n;
    rxq.delete();
    send_cmd(16'h0102);
    cmd = 16'hFFFF;
    wait_sent(n);
    checks++; if (n != 162) begin errors++; $display("FAIL held_latency got %0d exp 162", n); end
    checks++; if (two_bytes() !== 16'h0102) begin errors++; $display("FAIL held_bytes got %h exp 0102", two_bytes()); end
  endtask

  task automatic test_reset_mid_tx();
    int n;
    send_cmd(16'h3C3C);
    send_rx(8'h77);
    repeat (2) @(negedge clk);
    checks++; if (resp_rdy !== 1'b1) begin errors++; $display("FAIL resp_during_tx got %b exp 1", resp_rdy); end
    checks++; if (resp !== 8'h77) begin errors++; $display("FAIL resp_during_tx_val got %h exp 77", resp); end
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b exp 1", TX); end
    checks++; if (cmd_sent !== 1'b0) begin errors++; $display("FAIL midrst_cmd_sent got %b exp 0", cmd_sent); end
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL midrst_resp_rdy got %b exp 0", resp_rdy); end
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rxq.delete();
    send_cmd(16'hBEEF);
    wait_sent(n);
    checks++; if (n != 162) begin errors++; $display("FAIL beef_latency got %0d exp 162", n); end
    checks++; if (two_bytes() !== 16'hBEEF) begin errors++; $display("FAIL beef_bytes got %h exp beef", two_bytes()); end
  endtask

`ifdef RESP_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    int k;
    send_cmd(16'h5555);
    wait_sent(n);
    k = -1;
    for (int i = 1; i <= 1200; i++) begin
      @(posedge clk);
      #1;
      if (resp_timeout) begin
        k = i;
        break;
      end
    end
    checks++; if (k != 1000) begin errors++; $display("FAIL timeout_delay got %0d exp 1000", k); end
    send_cmd(16'h6666);
    checks++; if (resp_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b exp 0", resp_timeout); end
    wait_sent(n);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_cmd();
    test_response();
    test_ignored_snd();
    test_held_low_byte();
    test_reset_mid_tx();
`ifdef RESP_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_remote_comm
